// File: rtl/layer2_mac_neuron.sv
// layer2_mac_neuron: time-multiplexed output neuron for the second layer.
// Accumulates 48 activation x ternary-weight products, adds a bias,
// saturates to a signed 6-bit logit and pulses done for one cycle.
// The parent drives input_val/weight combinationally from mac_count_out,
// and holds bias stable while the evaluation runs.
module layer2_mac_neuron (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [1:0] input_val,
   input  logic [1:0] weight,
   input  logic [3:0] bias,
   output logic       done,
   output logic [5:0] result,
   output logic [5:0] mac_count_out
);

   localparam logic [5:0] LAST_INDEX = 6'd47;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      BIAS = 2'd2,
      OUT  = 2'd3
   } state_t;

   // state is kept as a named enum signal so checkers can bind to it
   state_t state;
   state_t state_next;

   logic signed [8:0] acc;
   logic signed [8:0] acc_next;
   logic        [5:0] count_next;
   logic        [5:0] result_next;
   logic              done_next;

   logic signed [8:0] act_ext;
   logic signed [8:0] product;
   logic signed [8:0] bias_ext;
   logic        [5:0] sat_val;

   // product of the current activation and the decoded ternary weight
   always_comb begin
      act_ext = {{7{input_val[1]}}, input_val};
      product = 9'sd0;
      case (weight)
         2'b01:   product = act_ext;
         2'b11:   product = -act_ext;
         default: product = 9'sd0;   // 00 is zero, 10 is reserved and treated as zero
      endcase
   end

   // sign-extended bias and the 6-bit saturated view of the accumulator
   always_comb begin
      bias_ext = {{5{bias[3]}}, bias};
      if (acc > 9'sd31) begin
         sat_val = 6'b011111;
      end else if (acc < -9'sd32) begin
         sat_val = 6'b100000;
      end else begin
         sat_val = acc[5:0];
      end
   end

   // next-state and next-value logic; done defaults low so it only pulses
   always_comb begin
      state_next  = state;
      acc_next    = acc;
      count_next  = mac_count_out;
      result_next = result;
      done_next   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               acc_next   = 9'sd0;
               count_next = 6'd0;
               state_next = MAC;
            end
         end
         MAC: begin
            acc_next = acc + product;
            if (mac_count_out == LAST_INDEX) begin
               state_next = BIAS;
            end else begin
               count_next = mac_count_out + 6'd1;
            end
         end
         BIAS: begin
            acc_next   = acc + bias_ext;
            state_next = OUT;
         end
         OUT: begin
            result_next = sat_val;
            done_next   = 1'b1;
            count_next  = 6'd0;
            state_next  = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // state and datapath registers; reset aborts any evaluation in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         acc           <= 9'sd0;
         mac_count_out <= 6'd0;
         result        <= 6'd0;
         done          <= 1'b0;
      end else begin
         state         <= state_next;
         acc           <= acc_next;
         mac_count_out <= count_next;
         result        <= result_next;
         done          <= done_next;
      end
   end

endmodule

// File: tb/tb_layer2_mac_neuron.sv
// Bench for layer2_mac_neuron: acts as the parent controller, driving
// activation/weight from mac_count_out, and scoreboards every done.
module tb_layer2_mac_neuron;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [1:0] input_val;
   logic [1:0] weight;
   logic [3:0] bias;
   logic       done;
   logic [5:0] result;
   logic [5:0] mac_count_out;

   int         pat;
   logic [1:0] rnd_in [48];
   logic [1:0] rnd_w  [48];
   int         checks = 0;
   int         errors = 0;
   logic [5:0] exp_q[$];
   logic [5:0] exp_v;

   layer2_mac_neuron dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .input_val     (input_val),
      .weight        (weight),
      .bias          (bias),
      .done          (done),
      .result        (result),
      .mac_count_out (mac_count_out)
   );

   // clock
   always #5 clk = ~clk;

   // activation pattern per index
   function automatic logic [1:0] in_of(int p, int k);
      if (k > 47) return 2'b00;
      case (p)
         1, 3, 7: return 2'b01;          // +1
         2, 8:    return 2'b11;          // -1
         5:       return 2'b10;          // -2
         default: return rnd_in[k];
      endcase
   endfunction

   // weight pattern per index
   function automatic logic [1:0] w_of(int p, int k);
      if (k > 47) return 2'b00;
      case (p)
         0:       return 2'b00;
         1, 2:    return 2'b01;
         3:       return (k % 2 == 1) ? 2'b11 : 2'b01;
         4:       return 2'b10;
         5:       return (k < 10) ? 2'b11 : 2'b00;
         7:       return (k < 26) ? 2'b01 : 2'b00;
         8:       return (k < 24) ? 2'b01 : 2'b00;
         default: return rnd_w[k];
      endcase
   endfunction

   // parent-side combinational address decode
   always_comb begin
      input_val = in_of(pat, int'(mac_count_out));
      weight    = w_of(pat, int'(mac_count_out));
   end

   // reference: integer dot product, bias, clamp to [-32, 31]
   function automatic logic [5:0] model(int p, int b);
      int sum;
      sum = 0;
      for (int k = 0; k < 48; k++) begin
         logic signed [1:0] a;
         logic [1:0] w;
         a = in_of(p, k);
         w = w_of(p, k);
         if (w == 2'b01) sum = sum + int'(a);
         else if (w == 2'b11) sum = sum - int'(a);
      end
      sum = sum + b;
      if (sum > 31) sum = 31;
      if (sum < -32) sum = -32;
      return 6'(sum);
   endfunction

   function automatic logic [5:0] exp_cnt(int n);
      if (n <= 47) return 6'(n);
      if (n <= 49) return 6'd47;
      return 6'd0;
   endfunction

   task automatic check(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // scoreboard: every done pops one expected result
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         checks++;
         assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_done: observed done=1 expected no pending evaluation");
         end
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check("result", $signed(result), $signed(exp_v));
         end
      end
   end

   // driver: set up an evaluation and raise start
   task automatic set_start(int p, int b);
      pat   = p;
      bias  = 4'(b);
      exp_q.push_back(model(p, b));
      start = 1'b1;
   endtask

   task automatic launch(int p, int b);
      set_start(p, b);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // follow one evaluation from E1 to E51 with bounded cycle count
   task automatic track(bit restart20, bit chk_cnt, bit chain, int p2, int b2);
      for (int n = 1; n <= 50; n++) begin
         @(posedge clk); #1;
         check("done_timing", done, (n == 50) ? 1 : 0);
         if (chk_cnt) check("mac_count", $signed({1'b0, mac_count_out}), $signed({1'b0, exp_cnt(n)}));
         if (restart20) begin
            if (n == 20) start = 1'b1;
            else if (n == 21) start = 1'b0;
         end
      end
      if (chain) set_start(p2, b2);
      @(posedge clk); #1;
      start = 1'b0;
      check("done_width", done, 0);
      check("count_after_done", $signed({1'b0, mac_count_out}), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      pat   = 0;
      bias  = 4'd0;
      for (int k = 0; k < 48; k++) begin
         rnd_in[k] = 2'($urandom_range(0, 3));
         rnd_w[k]  = 2'($urandom_range(0, 3));
      end

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_done", done, 0);
      check("rst_result", $signed(result), 0);
      check("rst_count", $signed({1'b0, mac_count_out}), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // directed patterns
      launch(0, 0);  track(0, 0, 0, 0, 0);   // all weights zero -> 0
      launch(1, 0);  track(0, 0, 0, 0, 0);   // +48 -> +31
      launch(2, -8); track(0, 0, 0, 0, 0);   // -56 -> -32
      launch(3, 5);  track(0, 0, 0, 0, 0);   // alternating -> +5
      launch(4, -6); track(0, 0, 0, 0, 0);   // reserved weights -> bias
      launch(5, 3);  track(0, 1, 0, 0, 0);   // +20 +3 -> +23, count walk
      launch(7, 5);  track(0, 0, 0, 0, 0);   // exactly +31
      launch(8, -8); track(0, 0, 0, 0, 0);   // exactly -32

      // ignored restart at count 20, then back-to-back start in done cycle
      launch(6, $urandom_range(0, 15) - 8);
      track(1, 0, 1, 3, 5);
      track(0, 1, 0, 0, 0);

      // idle long enough that any spurious done reaches the scoreboard
      repeat (55) @(posedge clk);
      #1;

      // mid-evaluation reset
      launch(8, -8); track(0, 0, 0, 0, 0);   // leaves result nonzero
      launch(6, 2);
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk); #1;
      end
      check("count_before_reset", $signed({1'b0, mac_count_out}), 30);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("abort_done", done, 0);
      check("abort_result", $signed(result), 0);
      check("abort_count", $signed({1'b0, mac_count_out}), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (55) @(posedge clk);
      #1;
      check("no_done_after_abort", done, 0);
      launch(5, 3);  track(0, 1, 0, 0, 0);   // fresh evaluation -> +23

      @(posedge clk); #1;
      check("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
